// File: rtl/spi_link_pkg.sv
// -----------------------------------------------------------------------------
// spi_link_pkg
// Shared types and helpers for the spi_link loopback unit.
//   master_state_t : master controller states
//   MIN_CLK_DIV    : smallest legal clk-per-half-SCLK divider.
//                    The slave's miso update lags the falling edge by one clk,
//                    so a divider of 1 would race the master's sample.
//   cnt_width()    : bits needed for a counter holding values 0..n-1
// -----------------------------------------------------------------------------
package spi_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } master_state_t;

    localparam int MIN_CLK_DIV = 2;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_link_if.sv
// -----------------------------------------------------------------------------
// spi_link_if
// Host-facing bundle for spi_link.
//   start, data_in       : host request and master transmit word
//   data_out, busy, done : master receive word and status
//   slave_tx             : slave transmit word
//   slave_rx, slave_rx_ready : slave receive word and completion flag
//   sclk, mosi, miso, cs_n   : observed SPI wires
// Modports:
//   master : the host / bench side (drives requests and slave_tx)
//   slave  : the spi_link block itself
// -----------------------------------------------------------------------------
interface spi_link_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] slave_tx;
    logic [WIDTH-1:0] slave_rx;
    logic             slave_rx_ready;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             cs_n;

    modport master (
        output start, data_in, slave_tx,
        input  data_out, busy, done, slave_rx, slave_rx_ready,
        input  sclk, mosi, miso, cs_n
    );

    modport slave (
        input  start, data_in, slave_tx,
        output data_out, busy, done, slave_rx, slave_rx_ready,
        output sclk, mosi, miso, cs_n
    );

endinterface

// File: rtl/spi_link_slave.sv
// -----------------------------------------------------------------------------
// spi_link_slave
// SPI mode-0 slave endpoint running in the system clock domain. SCLK and CS_N
// are registered once and edges are detected against that copy, so every
// slave action lands one clk after the corresponding wire transition.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   sclk, cs_n, mosi: SPI inputs from the master
//   miso            : SPI output, forced low while cs_n is high
//   slave_tx        : word loaded on cs_n falling
//   slave_rx        : last complete received word
//   slave_rx_ready  : set when a full word arrives, cleared on cs_n falling
// -----------------------------------------------------------------------------
module spi_link_slave
    import spi_link_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] slave_tx,
    output logic [WIDTH-1:0] slave_rx,
    output logic             slave_rx_ready
);

    localparam int BIT_W = cnt_width(WIDTH);

    logic             sclk_q_reg;
    logic             cs_n_q_reg;
    logic             miso_reg;
    logic             rx_ready_reg;
    logic [WIDTH-1:0] tx_shift_reg;
    logic [WIDTH-1:0] rx_word_reg;
    // Only WIDTH-1 bits are kept: the final bit goes straight into rx_word_reg.
    logic [WIDTH-2:0] rx_shift_reg;
    logic [BIT_W-1:0] bit_cnt_reg;

    logic cs_fall;
    logic sclk_rise;
    logic sclk_fall;

    assign cs_fall   = cs_n_q_reg & ~cs_n;
    assign sclk_rise = ~sclk_q_reg & sclk & ~cs_n;
    assign sclk_fall = sclk_q_reg & ~sclk & ~cs_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q_reg   <= 1'b0;
            cs_n_q_reg   <= 1'b1;
            miso_reg     <= 1'b0;
            rx_ready_reg <= 1'b0;
            tx_shift_reg <= '0;
            rx_word_reg  <= '0;
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            sclk_q_reg <= sclk;
            cs_n_q_reg <= cs_n;
            if (cs_n) begin
                miso_reg <= 1'b0;
            end else if (cs_fall) begin
                tx_shift_reg <= slave_tx;
                miso_reg     <= slave_tx[WIDTH-1];
                bit_cnt_reg  <= '0;
                rx_ready_reg <= 1'b0;
            end else if (sclk_rise) begin
                rx_shift_reg <= (WIDTH-1)'({rx_shift_reg, mosi});
                bit_cnt_reg  <= bit_cnt_reg + BIT_W'(1);
                if (bit_cnt_reg == BIT_W'(WIDTH - 1)) begin
                    rx_word_reg  <= {rx_shift_reg, mosi};
                    rx_ready_reg <= 1'b1;
                end
            end else if (sclk_fall) begin
                tx_shift_reg <= tx_shift_reg << 1;
                miso_reg     <= tx_shift_reg[WIDTH-2];
            end
        end
    end

    // The gate covers the single clk between cs_n rising and miso_reg clearing.
    assign miso           = miso_reg & ~cs_n;
    assign slave_rx       = rx_word_reg;
    assign slave_rx_ready = rx_ready_reg;

endmodule

// File: rtl/spi_link.sv
// -----------------------------------------------------------------------------
// spi_link
// SPI mode-0 master controller looped to an internal SPI slave endpoint.
// A start pulse in IDLE captures data_in, lowers cs_n and runs a full-duplex
// MSB-first exchange of WIDTH bits; done pulses with the slave's word on
// data_out.
// Ports:
//   clk : system clock (rising edge)
//   rst : synchronous active-high reset, aborts any transfer
//   bus : spi_link_if.slave (host handshake, slave words, SPI wires)
// Parameters:
//   WIDTH   : bits per transfer (>= 2)
//   CLK_DIV : clk cycles per SCLK half-period (>= 2)
// -----------------------------------------------------------------------------
module spi_link
    import spi_link_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic      clk,
    input  logic      rst,
    spi_link_if.slave bus
);

    // Clamp so a mis-set divider cannot break the miso sampling margin.
    localparam int DIV    = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
    localparam int DIV_W  = cnt_width(DIV);
    localparam int EDGES  = 2 * WIDTH;
    localparam int EDGE_W = cnt_width(EDGES + 1);

    master_state_t     state_reg;
    logic              sclk_reg;
    logic              cs_n_reg;
    logic              mosi_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [WIDTH-1:0]  data_out_reg;
    logic [WIDTH-1:0]  tx_shift_reg;
    logic [WIDTH-1:0]  rx_shift_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [EDGE_W-1:0] edge_cnt_reg;

    logic miso;
    logic div_last;

    assign div_last = (div_cnt_reg == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sclk_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            data_out_reg <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        tx_shift_reg <= bus.data_in;
                        mosi_reg     <= bus.data_in[WIDTH-1];
                        cs_n_reg     <= 1'b0;
                        busy_reg     <= 1'b1;
                        rx_shift_reg <= '0;
                        div_cnt_reg  <= '0;
                        edge_cnt_reg <= '0;
                        state_reg    <= SETUP;
                    end
                end

                // Half-period of cs_n-low setup; its last cycle issues the
                // first SCLK rise and samples the slave's MSB.
                SETUP: begin
                    if (div_last) begin
                        div_cnt_reg  <= '0;
                        sclk_reg     <= 1'b1;
                        rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], miso};
                        edge_cnt_reg <= EDGE_W'(1);
                        state_reg    <= XFER;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end

                // edge_cnt_reg counts SCLK edges already issued. One extra
                // half-period after the last falling edge gives the slave
                // hold time before cs_n rises.
                XFER: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (edge_cnt_reg == EDGE_W'(EDGES)) begin
                            cs_n_reg     <= 1'b1;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            data_out_reg <= rx_shift_reg;
                            state_reg    <= DONE;
                        end else begin
                            edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
                            sclk_reg     <= ~sclk_reg;
                            if (!sclk_reg) begin
                                rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], miso};
                            end else if (edge_cnt_reg != EDGE_W'(EDGES - 1)) begin
                                tx_shift_reg <= tx_shift_reg << 1;
                                mosi_reg     <= tx_shift_reg[WIDTH-2];
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end

                // done is visible for this one cycle; start is not looked at.
                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    spi_link_slave #(
        .WIDTH (WIDTH)
    ) u_slave (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk_reg),
        .cs_n           (cs_n_reg),
        .mosi           (mosi_reg),
        .miso           (miso),
        .slave_tx       (bus.slave_tx),
        .slave_rx       (bus.slave_rx),
        .slave_rx_ready (bus.slave_rx_ready)
    );

    assign bus.sclk     = sclk_reg;
    assign bus.cs_n     = cs_n_reg;
    assign bus.mosi     = mosi_reg;
    assign bus.miso     = miso;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.data_out = data_out_reg;

endmodule

// File: tb/tb_spi_link.sv
// -----------------------------------------------------------------------------
// tb_spi_link
// Directed bench for spi_link: an 8-bit / CLK_DIV=2 instance and a
// 16-bit / CLK_DIV=4 instance. Inputs change on the falling clock edge and
// outputs are sampled there, half a period away from the active edge.
// "lat" counts falling edges after the start request; lat n observes the
// state left by the n-th rising edge counted from the edge that took start.
// -----------------------------------------------------------------------------
module tb_spi_link;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    spi_link_if #(.WIDTH(8))  if8  ();
    spi_link_if #(.WIDTH(16)) if16 ();

    spi_link #(.WIDTH(8), .CLK_DIV(2)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    spi_link #(.WIDTH(16), .CLK_DIV(4)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, ".sclk"},     32'(if8.sclk),           32'd0);
        chk({tag, ".cs_n"},     32'(if8.cs_n),           32'd1);
        chk({tag, ".mosi"},     32'(if8.mosi),           32'd0);
        chk({tag, ".miso"},     32'(if8.miso),           32'd0);
        chk({tag, ".busy"},     32'(if8.busy),           32'd0);
        chk({tag, ".done"},     32'(if8.done),           32'd0);
        chk({tag, ".data_out"}, 32'(if8.data_out),       32'd0);
        chk({tag, ".slave_rx"}, 32'(if8.slave_rx),       32'd0);
        chk({tag, ".rx_ready"}, 32'(if8.slave_rx_ready), 32'd0);
    endtask

    // One 8-bit exchange; returns on the falling edge where done is seen.
    // poke raises start for one cycle in the middle of the transfer.
    task automatic xfer8(input logic [7:0] din, input logic [7:0] stx,
                         input bit poke, input string tag);
        int lat;
        if8.data_in  = din;
        if8.slave_tx = stx;
        if8.start    = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        lat = 1;
        chk({tag, ".cs_n_low"}, 32'(if8.cs_n), 32'd0);
        chk({tag, ".busy_hi"},  32'(if8.busy), 32'd1);
        while (if8.done !== 1'b1 && lat < 200) begin
            if (lat == 2) begin
                chk({tag, ".rdy_clr"},   32'(if8.slave_rx_ready), 32'd0);
                chk({tag, ".sclk_low"},  32'(if8.sclk),           32'd0);
            end
            if (lat == 3)  chk({tag, ".sclk_rise"}, 32'(if8.sclk),           32'd1);
            if (lat == 31) chk({tag, ".rdy_early"}, 32'(if8.slave_rx_ready), 32'd0);
            if (lat == 32) chk({tag, ".rdy_set"},   32'(if8.slave_rx_ready), 32'd1);
            if8.start = poke && (lat == 10);
            @(negedge clk);
            lat++;
        end
        if8.start = 1'b0;
        chk({tag, ".done_lat"}, 32'(lat),                 32'd35);
        chk({tag, ".data_out"}, 32'(if8.data_out),        32'(stx));
        chk({tag, ".slave_rx"}, 32'(if8.slave_rx),        32'(din));
        chk({tag, ".rx_ready"}, 32'(if8.slave_rx_ready),  32'd1);
        chk({tag, ".cs_n_hi"},  32'(if8.cs_n),            32'd1);
        chk({tag, ".busy_lo"},  32'(if8.busy),            32'd0);
    endtask

    initial begin
        int n;
        int rises;
        int cyc;
        int lat;
        logic prev;

        rst           = 1'b1;
        if8.start     = 1'b0;
        if8.data_in   = '0;
        if8.slave_tx  = '0;
        if16.start    = 1'b0;
        if16.data_in  = '0;
        if16.slave_tx = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk_reset8("rst");
        chk("rst.u16_cs_n", 32'(if16.cs_n), 32'd1);
        chk("rst.u16_busy", 32'(if16.busy), 32'd0);

        // Basic exchange A5 <-> 3C
        xfer8(8'hA5, 8'h3C, 1'b0, "x1");
        @(negedge clk);
        chk("x1.done_pulse", 32'(if8.done), 32'd0);
        @(negedge clk);

        // 5A <-> C3 with start poked mid-transfer, then during DONE
        xfer8(8'h5A, 8'hC3, 1'b1, "x2");
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        chk("x2.done_pulse",   32'(if8.done), 32'd0);
        chk("x2.done_ignored", 32'(if8.busy), 32'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (if8.done === 1'b1) n++;
        end
        chk("x2.extra_done", 32'(n),            32'd0);
        chk("x2.data_keep",  32'(if8.data_out), 32'h0000_00C3);

        // Reset on the 4th SCLK rise aborts the transfer
        if8.data_in  = 8'hA5;
        if8.slave_tx = 8'h3C;
        if8.start    = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        rises = 0;
        cyc   = 0;
        while (rises < 4 && cyc < 100) begin
            prev = if8.sclk;
            @(negedge clk);
            cyc++;
            if (prev === 1'b0 && if8.sclk === 1'b1) rises++;
        end
        chk("abort.rises", 32'(rises), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        chk_reset8("abort");
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (if8.done === 1'b1) n++;
        end
        chk("abort.no_done", 32'(n), 32'd0);

        // Recovery transfer FF <-> 00
        xfer8(8'hFF, 8'h00, 1'b0, "x3");
        @(negedge clk);

        // Back-to-back: second start on the cycle after done
        xfer8(8'h12, 8'h34, 1'b0, "b1");
        @(negedge clk);
        xfer8(8'h87, 8'hE1, 1'b0, "b2");
        @(negedge clk);

        // 16-bit, CLK_DIV=4: BEEF <-> 1234, done at k+1+4*33
        if16.data_in  = 16'hBEEF;
        if16.slave_tx = 16'h1234;
        if16.start    = 1'b1;
        @(negedge clk);
        if16.start = 1'b0;
        lat = 1;
        while (if16.done !== 1'b1 && lat < 400) begin
            if (lat == 4) chk("w16.sclk_low",  32'(if16.sclk), 32'd0);
            if (lat == 5) chk("w16.sclk_rise", 32'(if16.sclk), 32'd1);
            @(negedge clk);
            lat++;
        end
        chk("w16.done_lat", 32'(lat),                  32'd133);
        chk("w16.data_out", 32'(if16.data_out),        32'h0000_1234);
        chk("w16.slave_rx", 32'(if16.slave_rx),        32'h0000_BEEF);
        chk("w16.rx_ready", 32'(if16.slave_rx_ready),  32'd1);
        chk("w16.cs_n_hi",  32'(if16.cs_n),            32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
